// File: rtl/spi_amm_pkg.sv
// Shared frame constants, slave FSM encoding and the XOR frame CRC
// used by the SPI-over-Avalon far-end slave.
package spi_amm_pkg;

   localparam logic [31:0] WRITE_WORD = 32'hAAAA_AAAA;
   localparam logic [31:0] READ_WORD  = 32'hBBBB_BBBB;

   typedef enum logic [2:0] {
      IDLE,
      RX,
      AVM_WR,
      AVM_RD,
      ACK,
      TX,
      HOLD,
      DRAIN
   } slv_state_t;

   function automatic logic [31:0] frame_crc(input logic [31:0] pre,
                                             input logic [31:0] addr,
                                             input logic [31:0] data);
      return pre ^ addr ^ data;
   endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// Synchronises SCLK, nSS and MOSI into main_clk and produces single-cycle
// SCLK-rise and nSS-edge strobes aligned with the synchronised MOSI level.
module spi_slave_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic sclk_i,
   input  logic nss_i,
   input  logic mosi_i,
   output logic sclk_rise,
   output logic nss_fall,
   output logic nss_rise,
   output logic mosi_s,
   output logic nss_s
);

   logic [SYNC_STAGES-1:0] sclk_sync_q;
   logic [SYNC_STAGES-1:0] nss_sync_q;
   logic [SYNC_STAGES-1:0] mosi_sync_q;
   logic                   sclk_prev_q;
   logic                   nss_prev_q;

   // nSS chain resets to the deselected level so reset release is not seen as a frame start
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sclk_sync_q <= '0;
         nss_sync_q  <= '1;
         mosi_sync_q <= '0;
         sclk_prev_q <= 1'b0;
         nss_prev_q  <= 1'b1;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
         nss_sync_q  <= {nss_sync_q[SYNC_STAGES-2:0], nss_i};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
         sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
         nss_prev_q  <= nss_sync_q[SYNC_STAGES-1];
      end
   end

   assign sclk_rise = sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
   assign nss_fall  = ~nss_sync_q[SYNC_STAGES-1] & nss_prev_q;
   assign nss_rise  = nss_sync_q[SYNC_STAGES-1] & ~nss_prev_q;
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign nss_s     = nss_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_ams_slave.sv
// Far-end SPI slave: decodes write/read frames, runs one Avalon-MM master
// transaction per frame and answers with ACK, read data and read CRC on MISO.
module spi_ams_slave
   import spi_amm_pkg::*;
#(
   parameter int ADDR_WIDTH  = 30,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  main_clk,
   input  logic                  main_reset,
   input  logic                  SCLK,
   input  logic                  nSS,
   input  logic                  MOSI,
   output logic                  MISO,
   output logic [ADDR_WIDTH-1:0] avm_address,
   output logic [31:0]           avm_writedata,
   output logic                  avm_write,
   output logic                  avm_read,
   input  logic [31:0]           avm_readdata,
   input  logic                  avm_readdatavalid,
   input  logic                  avm_waitrequest,
   input  logic [1:0]            avm_response,
   output logic                  crc_error,
   output logic                  frame_error
);

   logic sclk_rise;
   logic nss_fall;
   logic nss_rise;
   logic mosi_s;
   logic nss_s;

   spi_slave_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk_i     (main_clk),
      .rst_i     (main_reset),
      .sclk_i    (SCLK),
      .nss_i     (nSS),
      .mosi_i    (MOSI),
      .sclk_rise (sclk_rise),
      .nss_fall  (nss_fall),
      .nss_rise  (nss_rise),
      .mosi_s    (mosi_s),
      .nss_s     (nss_s)
   );

   slv_state_t  state_q;
   logic [5:0]  bit_cnt_q;
   logic [1:0]  word_idx_q;
   logic [30:0] rx_q;
   logic [63:0] tx_q;
   logic [31:0] addr_q;
   logic [31:0] data_q;
   logic        is_read_q;
   logic        miso_q;
   logic        avm_write_q;
   logic        avm_read_q;
   logic        rd_pend_q;
   logic        crc_error_q;
   logic        frame_error_q;

   logic [31:0] rx_word_d;
   logic        word_done;
   logic        wr_ack;
   logic        rd_acc;
   logic        rd_done;
   logic        drain_busy;

   // The 32nd bit is taken straight from the line, so the shifter only holds 31
   assign rx_word_d  = {rx_q, mosi_s};
   assign word_done  = (bit_cnt_q == 6'd31);
   assign wr_ack     = avm_write_q & ~avm_waitrequest;
   assign rd_acc     = avm_read_q & ~avm_waitrequest;
   assign rd_done    = rd_pend_q & avm_readdatavalid;
   assign drain_busy = (avm_write_q & ~wr_ack) | avm_read_q | (rd_pend_q & ~rd_done);

   always_ff @(posedge main_clk) begin
      if (main_reset) begin
         state_q       <= IDLE;
         bit_cnt_q     <= '0;
         word_idx_q    <= '0;
         rx_q          <= '0;
         tx_q          <= '0;
         addr_q        <= '0;
         data_q        <= '0;
         is_read_q     <= 1'b0;
         miso_q        <= 1'b1;
         avm_write_q   <= 1'b0;
         avm_read_q    <= 1'b0;
         rd_pend_q     <= 1'b0;
         crc_error_q   <= 1'b0;
         frame_error_q <= 1'b0;
      end else begin
         crc_error_q   <= 1'b0;
         frame_error_q <= 1'b0;

         // Bus handshakes run independently of the state so DRAIN can reuse them
         if (wr_ack) begin
            avm_write_q <= 1'b0;
         end
         if (rd_acc) begin
            avm_read_q <= 1'b0;
            rd_pend_q  <= 1'b1;
         end
         if (rd_done) begin
            rd_pend_q <= 1'b0;
         end

         case (state_q)
            IDLE: begin
               miso_q <= 1'b1;
               if (nss_fall) begin
                  state_q    <= RX;
                  bit_cnt_q  <= '0;
                  word_idx_q <= '0;
               end
            end

            RX: begin
               if (nss_rise) begin
                  frame_error_q <= 1'b1;
                  miso_q        <= 1'b1;
                  state_q       <= IDLE;
               end else if (sclk_rise) begin
                  rx_q      <= rx_word_d[30:0];
                  bit_cnt_q <= word_done ? 6'd0 : bit_cnt_q + 6'd1;
                  if (word_done) begin
                     word_idx_q <= word_idx_q + 2'd1;
                     case (word_idx_q)
                        2'd0: begin
                           if (rx_word_d == WRITE_WORD) begin
                              is_read_q <= 1'b0;
                           end else if (rx_word_d == READ_WORD) begin
                              is_read_q <= 1'b1;
                           end else begin
                              frame_error_q <= 1'b1;
                              state_q       <= HOLD;
                           end
                        end
                        2'd1: begin
                           addr_q <= rx_word_d;
                           if (is_read_q) begin
                              avm_read_q <= 1'b1;
                              state_q    <= AVM_RD;
                           end
                        end
                        2'd2: begin
                           data_q <= rx_word_d;
                        end
                        default: begin
                           if (rx_word_d == frame_crc(WRITE_WORD, addr_q, data_q)) begin
                              avm_write_q <= 1'b1;
                              state_q     <= AVM_WR;
                           end else begin
                              crc_error_q <= 1'b1;
                              state_q     <= HOLD;
                           end
                        end
                     endcase
                  end
               end
            end

            AVM_WR: begin
               if (nss_rise) begin
                  frame_error_q <= 1'b1;
                  miso_q        <= 1'b1;
                  state_q       <= wr_ack ? IDLE : DRAIN;
               end else if (wr_ack) begin
                  state_q <= ACK;
               end
            end

            AVM_RD: begin
               if (nss_rise) begin
                  frame_error_q <= 1'b1;
                  miso_q        <= 1'b1;
                  state_q       <= rd_done ? IDLE : DRAIN;
               end else if (rd_done) begin
                  // An error response withholds the ACK so the master times out
                  if (avm_response == 2'b00) begin
                     tx_q    <= {avm_readdata, frame_crc(READ_WORD, addr_q, avm_readdata)};
                     state_q <= ACK;
                  end else begin
                     state_q <= HOLD;
                  end
               end
            end

            ACK: begin
               if (nss_rise) begin
                  frame_error_q <= 1'b1;
                  miso_q        <= 1'b1;
                  state_q       <= IDLE;
               end else if (sclk_rise) begin
                  miso_q    <= 1'b0;
                  bit_cnt_q <= '0;
                  state_q   <= is_read_q ? TX : HOLD;
               end
            end

            TX: begin
               if (nss_rise) begin
                  frame_error_q <= 1'b1;
                  miso_q        <= 1'b1;
                  state_q       <= IDLE;
               end else if (sclk_rise) begin
                  miso_q    <= tx_q[63];
                  tx_q      <= {tx_q[62:0], 1'b1};
                  bit_cnt_q <= bit_cnt_q + 6'd1;
                  if (bit_cnt_q == 6'd63) begin
                     state_q <= HOLD;
                  end
               end
            end

            HOLD: begin
               if (nss_s) begin
                  miso_q  <= 1'b1;
                  state_q <= IDLE;
               end else if (sclk_rise) begin
                  miso_q <= 1'b1;
               end
            end

            DRAIN: begin
               // A frame that started while draining is skipped via HOLD
               if (!drain_busy) begin
                  miso_q  <= 1'b1;
                  state_q <= nss_s ? IDLE : HOLD;
               end
            end

            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign MISO          = miso_q;
   assign avm_address   = addr_q[ADDR_WIDTH-1:0];
   assign avm_writedata = data_q;
   assign avm_write     = avm_write_q;
   assign avm_read      = avm_read_q;
   assign crc_error     = crc_error_q;
   assign frame_error   = frame_error_q;

endmodule

// File: tb/tb_spi_ams_slave.sv
// Directed bench for spi_ams_slave: bit-banged SPI master, Avalon slave model
// and a scoreboard of expected bus transactions.
module tb_spi_ams_slave;
   import spi_amm_pkg::*;

   localparam int ADDR_WIDTH = 30;
   localparam int W          = 64;

   logic                  main_clk = 1'b0;
   logic                  main_reset = 1'b1;
   logic                  SCLK = 1'b0;
   logic                  nSS = 1'b1;
   logic                  MOSI = 1'b0;
   logic                  MISO;
   logic [ADDR_WIDTH-1:0] avm_address;
   logic [31:0]           avm_writedata;
   logic                  avm_write;
   logic                  avm_read;
   logic [31:0]           avm_readdata = 32'h0;
   logic                  avm_readdatavalid = 1'b0;
   logic                  avm_waitrequest = 1'b0;
   logic [1:0]            avm_response = 2'b00;
   logic                  crc_error;
   logic                  frame_error;

   logic [W-1:0] exp_q[$];
   int n_checks = 0;
   int n_fail = 0;
   int crc_err_cnt = 0;
   int frm_err_cnt = 0;
   int bus_txn_cnt = 0;
   int rd_strobe_cnt = 0;
   int wait_cfg = 0;
   int rd_lat_cfg = 5;
   int wait_cnt = 0;
   int rd_lat_cnt = 0;
   logic [31:0] rd_data_cfg = 32'h0;
   logic [1:0]  rsp_cfg = 2'b00;

   always #5 main_clk = ~main_clk;

   spi_ams_slave #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .SYNC_STAGES(2)
   ) dut (
      .main_clk          (main_clk),
      .main_reset        (main_reset),
      .SCLK              (SCLK),
      .nSS               (nSS),
      .MOSI              (MOSI),
      .MISO              (MISO),
      .avm_address       (avm_address),
      .avm_writedata     (avm_writedata),
      .avm_write         (avm_write),
      .avm_read          (avm_read),
      .avm_readdata      (avm_readdata),
      .avm_readdatavalid (avm_readdatavalid),
      .avm_waitrequest   (avm_waitrequest),
      .avm_response      (avm_response),
      .crc_error         (crc_error),
      .frame_error       (frame_error)
   );

   function automatic logic [31:0] tb_crc(input logic [31:0] p, input logic [31:0] a,
                                          input logic [31:0] d);
      return p ^ a ^ d;
   endfunction

   function automatic logic [W-1:0] exp_word(input logic is_wr, input logic [31:0] addr,
                                             input logic [31:0] data);
      return {is_wr, 1'b0, addr[ADDR_WIDTH-1:0], is_wr ? data : 32'h0};
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   // Avalon slave model and scoreboard consumer; also counts error pulses
   always @(negedge main_clk) begin
      if (crc_error) crc_err_cnt++;
      if (frame_error) frm_err_cnt++;
      avm_readdatavalid = 1'b0;
      if (rd_lat_cnt > 0) begin
         rd_lat_cnt--;
         if (rd_lat_cnt == 0) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = rd_data_cfg;
            avm_response      = rsp_cfg;
         end
      end
      if (avm_read) rd_strobe_cnt++;
      if (avm_write || avm_read) begin
         if (wait_cnt < wait_cfg) begin
            avm_waitrequest = 1'b1;
            wait_cnt++;
         end else begin
            avm_waitrequest = 1'b0;
            wait_cnt = 0;
            bus_txn_cnt++;
            check("bus_expected", 128'(exp_q.size() > 0), 128'd1);
            if (exp_q.size() > 0)
               check("bus_txn", 128'({avm_write, 1'b0, avm_address,
                                      avm_write ? avm_writedata : 32'h0}),
                     128'(exp_q.pop_front()));
            if (avm_read) rd_lat_cnt = rd_lat_cfg;
         end
      end else begin
         avm_waitrequest = 1'b0;
         wait_cnt = 0;
      end
   end

   initial begin
      repeat (60000) @(posedge main_clk);
      $display("FAIL watchdog: observed timeout required finish");
      $fatal(1, "watchdog expired");
   end

   task automatic spi_bit(input logic d, output logic q);
      MOSI = d;
      repeat (8) @(negedge main_clk);
      SCLK = 1'b1;
      repeat (8) @(negedge main_clk);
      SCLK = 1'b0;
      q = MISO;
   endtask

   task automatic spi_frame(input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] w2, input logic [31:0] w3,
                            input int n_words, input int n_resp, input int tail,
                            input logic raise, output logic [127:0] resp,
                            output logic req_ones);
      logic [31:0] words [4];
      logic m;
      words[0] = w0;
      words[1] = w1;
      words[2] = w2;
      words[3] = w3;
      resp     = '1;
      req_ones = 1'b1;
      nSS = 1'b0;
      repeat (8) @(negedge main_clk);
      for (int w = 0; w < n_words; w++) begin
         for (int b = 31; b >= 0; b--) begin
            spi_bit(words[w][b], m);
            req_ones = req_ones & m;
         end
      end
      for (int i = 0; i < n_resp; i++) begin
         spi_bit(1'b0, m);
         resp = {resp[126:0], m};
      end
      MOSI = 1'b0;
      if (raise) begin
         repeat (tail) @(negedge main_clk);
         nSS = 1'b1;
         repeat (40) @(negedge main_clk);
      end
   endtask

   initial begin
      logic [127:0] resp;
      logic         ones;
      logic [31:0]  d;
      int c0, f0, b0, r0;

      // Reset values
      repeat (5) @(negedge main_clk);
      check("rst_miso", 128'(MISO), 128'd1);
      check("rst_write", 128'(avm_write), 128'd0);
      check("rst_read", 128'(avm_read), 128'd0);
      check("rst_addr", 128'(avm_address), 128'd0);
      check("rst_wdata", 128'(avm_writedata), 128'd0);
      check("rst_errs", 128'({crc_error, frame_error}), 128'd0);
      check("rst_state", 128'(dut.state_q), 128'(IDLE));
      main_reset = 1'b0;
      repeat (5) @(negedge main_clk);

      // 1: good write frame
      c0 = crc_err_cnt; f0 = frm_err_cnt; b0 = bus_txn_cnt;
      exp_q.push_back(exp_word(1'b1, 32'h10, 32'hDEAD_BEEF));
      spi_frame(32'hAAAA_AAAA, 32'h10, 32'hDEAD_BEEF, 32'h7407_1455, 4, 40, 8, 1'b1, resp, ones);
      check("t1_ack_bits", 128'(resp[39:0]), 128'(40'h7F_FFFF_FFFF));
      check("t1_req_miso", 128'(ones), 128'd1);
      check("t1_bus_cnt", 128'(bus_txn_cnt - b0), 128'd1);
      check("t1_errs", 128'((crc_err_cnt - c0) + (frm_err_cnt - f0)), 128'd0);

      // 2: read frame, data after 5 cycles
      b0 = bus_txn_cnt;
      rd_data_cfg = 32'h1234_5678;
      exp_q.push_back(exp_word(1'b0, 32'h20, 32'h0));
      spi_frame(32'hBBBB_BBBB, 32'h20, 32'h0, 32'h0, 2, 72, 8, 1'b1, resp, ones);
      check("t2_resp", 128'(resp[71:0]), 128'({1'b0, 32'h1234_5678, 32'hA98F_EDE3, 7'h7F}));
      check("t2_bus_cnt", 128'(bus_txn_cnt - b0), 128'd1);

      // 3: corrupted CRC
      c0 = crc_err_cnt; b0 = bus_txn_cnt;
      spi_frame(32'hAAAA_AAAA, 32'h10, 32'hDEAD_BEEF, 32'h7407_1454, 4, 40, 8, 1'b1, resp, ones);
      check("t3_miso", 128'(resp[39:0]), 128'(40'hFF_FFFF_FFFF));
      check("t3_crc_err", 128'(crc_err_cnt - c0), 128'd1);
      check("t3_bus_cnt", 128'(bus_txn_cnt - b0), 128'd0);

      // 4: bad preamble
      f0 = frm_err_cnt; b0 = bus_txn_cnt;
      spi_frame(32'hCCCC_CCCC, 32'h10, 32'hDEAD_BEEF, 32'h7407_1455, 4, 40, 8, 1'b1, resp, ones);
      check("t4_frm_err", 128'(frm_err_cnt - f0), 128'd1);
      check("t4_bus_cnt", 128'(bus_txn_cnt - b0), 128'd0);
      check("t4_miso", 128'(resp[39:0]), 128'(40'hFF_FFFF_FFFF));
      check("t4_state", 128'(dut.state_q), 128'(IDLE));

      // Error response: no ACK
      rsp_cfg = 2'b10;
      rd_data_cfg = 32'h5555_AAAA;
      exp_q.push_back(exp_word(1'b0, 32'h28, 32'h0));
      spi_frame(32'hBBBB_BBBB, 32'h28, 32'h0, 32'h0, 2, 72, 8, 1'b1, resp, ones);
      check("terr_miso", 128'(resp[71:0]), 128'({72{1'b1}}));
      rsp_cfg = 2'b00;

      // 5: nSS rises while the read is stalled
      wait_cfg = 10;
      f0 = frm_err_cnt; b0 = bus_txn_cnt; r0 = rd_strobe_cnt;
      rd_data_cfg = 32'h7777_0000;
      exp_q.push_back(exp_word(1'b0, 32'h30, 32'h0));
      spi_frame(32'hBBBB_BBBB, 32'h30, 32'h0, 32'h0, 2, 0, 0, 1'b1, resp, ones);
      check("t5_frm_err", 128'(frm_err_cnt - f0), 128'd1);
      check("t5_rd_hold", 128'(rd_strobe_cnt - r0), 128'd11);
      check("t5_bus_cnt", 128'(bus_txn_cnt - b0), 128'd1);
      check("t5_read_low", 128'(avm_read), 128'd0);
      check("t5_miso", 128'(MISO), 128'd1);
      check("t5_state", 128'(dut.state_q), 128'(IDLE));
      wait_cfg = 0;

      d = tb_crc(32'hAAAA_AAAA, 32'h44, 32'h0BAD_F00D);
      exp_q.push_back(exp_word(1'b1, 32'h44, 32'h0BAD_F00D));
      spi_frame(32'hAAAA_AAAA, 32'h44, 32'h0BAD_F00D, d, 4, 40, 8, 1'b1, resp, ones);
      check("t5_wr_ack", 128'(resp[39:0]), 128'(40'h7F_FFFF_FFFF));

      // 6: reset during TX
      d = 32'hCAFE_F00D;
      rd_data_cfg = d;
      exp_q.push_back(exp_word(1'b0, 32'h50, 32'h0));
      spi_frame(32'hBBBB_BBBB, 32'h50, 32'h0, 32'h0, 2, 20, 0, 1'b0, resp, ones);
      check("t6_partial", 128'(resp[19:0]), 128'({1'b0, d[31:13]}));
      main_reset = 1'b1;
      nSS = 1'b1;
      @(negedge main_clk);
      check("t6_miso", 128'(MISO), 128'd1);
      check("t6_strobes", 128'({avm_write, avm_read}), 128'd0);
      check("t6_state", 128'(dut.state_q), 128'(IDLE));
      main_reset = 1'b0;
      repeat (10) @(negedge main_clk);

      d = 32'h0F0F_1234;
      rd_data_cfg = d;
      exp_q.push_back(exp_word(1'b0, 32'h3C, 32'h0));
      spi_frame(32'hBBBB_BBBB, 32'h3C, 32'h0, 32'h0, 2, 72, 8, 1'b1, resp, ones);
      check("t6_resp", 128'(resp[71:0]),
            128'({1'b0, d, tb_crc(32'hBBBB_BBBB, 32'h3C, d), 7'h7F}));

      check("sb_empty", 128'(exp_q.size()), 128'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
